// File: rtl/rv32i_pkg.sv
// Shared types for the RV32I hazard/forwarding controller: FSM states,
// operand-forward selectors and the hard-wired zero register index.
package rv32i_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        LSTALL = 2'd1,
        FLUSH  = 2'd2,
        HALT   = 2'd3
    } hz_state_e;

    typedef enum logic [1:0] {
        FWD_RF  = 2'd0,
        FWD_EX  = 2'd1,
        FWD_MEM = 2'd2,
        FWD_WB  = 2'd3
    } fwd_sel_e;

    localparam int unsigned REG_X0 = 0;

endpackage

// File: rtl/rv32i_fwd_mux.sv
// Operand source selection for one ID-stage register read: picks the
// youngest in-flight producer of rs and flags RAW / load-use matches.
module rv32i_fwd_mux
    import rv32i_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int RW     = 5,
    parameter int FWD_EN = 1
) (
    input  logic [RW-1:0]   rs,
    input  logic            use_i,
    input  logic            ex_valid,
    input  logic            ex_we,
    input  logic            ex_is_load,
    input  logic [RW-1:0]   ex_rd,
    input  logic [XLEN-1:0] ex_result,
    input  logic            mem_valid,
    input  logic            mem_we,
    input  logic [RW-1:0]   mem_rd,
    input  logic [XLEN-1:0] mem_result,
    input  logic            wb_valid,
    input  logic            wb_we,
    input  logic [RW-1:0]   wb_rd,
    input  logic [XLEN-1:0] wb_data,
    input  logic [XLEN-1:0] rf_op,
    output logic [XLEN-1:0] op_o,
    output logic            raw_o,
    output logic            load_hit_o
);

    logic     rs_nz_s;
    logic     ex_hit_s;
    logic     mem_hit_s;
    logic     wb_hit_s;
    fwd_sel_e sel_s;

    // Producer matching and priority select; x0 never matches anything.
    always_comb begin
        rs_nz_s    = (rs != RW'(REG_X0));
        ex_hit_s   = ex_valid & ex_we & (ex_rd == rs) & rs_nz_s;
        mem_hit_s  = mem_valid & mem_we & (mem_rd == rs) & rs_nz_s;
        wb_hit_s   = wb_valid & wb_we & (wb_rd == rs) & rs_nz_s;
        raw_o      = use_i & (ex_hit_s | mem_hit_s | wb_hit_s);
        load_hit_o = use_i & ex_hit_s & ex_is_load;

        // A load in EX has no data yet, so it falls through to older stages.
        if (FWD_EN == 0 || !rs_nz_s) begin
            sel_s = FWD_RF;
        end else if (ex_hit_s && !ex_is_load) begin
            sel_s = FWD_EX;
        end else if (mem_hit_s) begin
            sel_s = FWD_MEM;
        end else if (wb_hit_s) begin
            sel_s = FWD_WB;
        end else begin
            sel_s = FWD_RF;
        end
    end

    // Data mux driven by the chosen source.
    always_comb begin
        op_o = '0;
        case (sel_s)
            FWD_EX:  op_o = ex_result;
            FWD_MEM: op_o = mem_result;
            FWD_WB:  op_o = wb_data;
            FWD_RF: begin
                if (rs_nz_s) begin
                    op_o = rf_op;
                end else begin
                    op_o = '0;
                end
            end
            default: op_o = '0;
        endcase
    end

endmodule

// File: rtl/rv32i_hazard_unit.sv
// Hazard, forwarding and redirect controller for the 5-stage RV32I pipeline:
// operand forwarding, load-use stalls, taken-branch flush and halt.
module rv32i_hazard_unit
    import rv32i_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int NREG        = 32,
    parameter int LOAD_LAT    = 1,
    parameter int FLUSH_DEPTH = 2,
    parameter int FWD_EN      = 1,
    localparam int RW         = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [RW-1:0]   id_rs1,
    input  logic [RW-1:0]   id_rs2,
    input  logic            id_use1,
    input  logic            id_use2,
    input  logic            ex_valid,
    input  logic            ex_we,
    input  logic            ex_is_load,
    input  logic [RW-1:0]   ex_rd,
    input  logic [XLEN-1:0] ex_result,
    input  logic            mem_valid,
    input  logic            mem_we,
    input  logic [RW-1:0]   mem_rd,
    input  logic [XLEN-1:0] mem_result,
    input  logic            wb_valid,
    input  logic            wb_we,
    input  logic [RW-1:0]   wb_rd,
    input  logic [XLEN-1:0] wb_data,
    input  logic [XLEN-1:0] rf_op1,
    input  logic [XLEN-1:0] rf_op2,
    input  logic            branch_taken_i,
    input  logic [XLEN-1:0] branch_target_i,
    input  logic            halt_i,
    output logic [XLEN-1:0] op1_o,
    output logic [XLEN-1:0] op2_o,
    output logic            stall_o,
    output logic            bubble_o,
    output logic            flush_o,
    output logic            redirect_valid_o,
    output logic [XLEN-1:0] redirect_pc_o,
    output logic            halted_o,
    output logic [XLEN-1:0] stall_cnt_o,
    output logic [XLEN-1:0] flush_cnt_o
);

    localparam int LCW = $clog2(LOAD_LAT + 1);
    localparam int FCW = $clog2(FLUSH_DEPTH + 1);

    hz_state_e       state_q, state_d;
    logic [LCW-1:0]  lcnt_q, lcnt_d;
    logic [FCW-1:0]  fcnt_q, fcnt_d;
    logic            flush_q, flush_d;
    logic            halted_q, halted_d;
    logic            redirect_valid_q, redirect_valid_d;
    logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;
    logic [XLEN-1:0] stall_cnt_q, stall_cnt_d;
    logic [XLEN-1:0] flush_cnt_q, flush_cnt_d;

    logic raw1_s, raw2_s, lhit1_s, lhit2_s;
    logic load_use_s, hazard_s, branch_s, stall_s;

    rv32i_fwd_mux #(.XLEN(XLEN), .RW(RW), .FWD_EN(FWD_EN)) u_fwd1 (
        .rs(id_rs1), .use_i(id_use1),
        .ex_valid(ex_valid), .ex_we(ex_we), .ex_is_load(ex_is_load),
        .ex_rd(ex_rd), .ex_result(ex_result),
        .mem_valid(mem_valid), .mem_we(mem_we), .mem_rd(mem_rd), .mem_result(mem_result),
        .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .rf_op(rf_op1), .op_o(op1_o), .raw_o(raw1_s), .load_hit_o(lhit1_s)
    );

    rv32i_fwd_mux #(.XLEN(XLEN), .RW(RW), .FWD_EN(FWD_EN)) u_fwd2 (
        .rs(id_rs2), .use_i(id_use2),
        .ex_valid(ex_valid), .ex_we(ex_we), .ex_is_load(ex_is_load),
        .ex_rd(ex_rd), .ex_result(ex_result),
        .mem_valid(mem_valid), .mem_we(mem_we), .mem_rd(mem_rd), .mem_result(mem_result),
        .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .rf_op(rf_op2), .op_o(op2_o), .raw_o(raw2_s), .load_hit_o(lhit2_s)
    );

    // Hazard detection and the same-cycle stall/bubble request.
    always_comb begin
        load_use_s = lhit1_s | lhit2_s;
        if (FWD_EN == 0) begin
            hazard_s = load_use_s | raw1_s | raw2_s;
        end else begin
            hazard_s = load_use_s;
        end
        // Halt outranks a branch; a taken branch kills any stall it coincides with.
        branch_s = branch_taken_i & ex_valid & ~halt_i &
                   ((state_q == RUN) | (state_q == LSTALL));
        stall_s = 1'b0;
        case (state_q)
            RUN:     stall_s = hazard_s & ~branch_s;
            LSTALL:  stall_s = ~branch_s;
            FLUSH:   stall_s = 1'b0;
            HALT:    stall_s = 1'b1;
            default: stall_s = 1'b0;
        endcase
        stall_o  = stall_s;
        bubble_o = stall_s;
    end

    // Next-state, redirect and counter computation.
    always_comb begin
        state_d          = state_q;
        lcnt_d           = lcnt_q;
        fcnt_d           = fcnt_q;
        redirect_valid_d = 1'b0;
        redirect_pc_d    = redirect_pc_q;
        if (halt_i) begin
            state_d = HALT;
        end else if (branch_s) begin
            state_d          = FLUSH;
            fcnt_d           = FCW'(FLUSH_DEPTH - 1);
            lcnt_d           = '0;
            redirect_valid_d = 1'b1;
            redirect_pc_d    = branch_target_i;
        end else begin
            case (state_q)
                RUN: begin
                    if (load_use_s && LOAD_LAT > 1) begin
                        state_d = LSTALL;
                        lcnt_d  = LCW'(LOAD_LAT - 1);
                    end else begin
                        state_d = RUN;
                    end
                end
                LSTALL: begin
                    if (lcnt_q == LCW'(1)) begin
                        state_d = RUN;
                        lcnt_d  = '0;
                    end else begin
                        lcnt_d = lcnt_q - LCW'(1);
                    end
                end
                FLUSH: begin
                    if (fcnt_q == '0) begin
                        state_d = RUN;
                    end else begin
                        fcnt_d = fcnt_q - FCW'(1);
                    end
                end
                HALT:    state_d = HALT;
                default: state_d = RUN;
            endcase
        end
        flush_d  = (state_d == FLUSH);
        halted_d = (state_d == HALT);

        if (stall_s && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + XLEN'(1);
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
        if (redirect_valid_q && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + XLEN'(1);
        end else begin
            flush_cnt_d = flush_cnt_q;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= RUN;
            lcnt_q           <= '0;
            fcnt_q           <= '0;
            flush_q          <= 1'b0;
            halted_q         <= 1'b0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            stall_cnt_q      <= '0;
            flush_cnt_q      <= '0;
        end else begin
            state_q          <= state_d;
            lcnt_q           <= lcnt_d;
            fcnt_q           <= fcnt_d;
            flush_q          <= flush_d;
            halted_q         <= halted_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
            stall_cnt_q      <= stall_cnt_d;
            flush_cnt_q      <= flush_cnt_d;
        end
    end

    assign flush_o          = flush_q;
    assign halted_o         = halted_q;
    assign redirect_valid_o = redirect_valid_q;
    assign redirect_pc_o    = redirect_pc_q;
    assign stall_cnt_o      = stall_cnt_q;
    assign flush_cnt_o      = flush_cnt_q;

endmodule

// File: tb/tb_rv32i_hazard_unit.sv
// Scoreboard bench: two hazard units (forwarding on, LOAD_LAT=3; forwarding off,
// LOAD_LAT=1) driven from shared directed vectors with hand-computed expectations.
module tb_rv32i_hazard_unit;

    localparam int XLEN = 32;
    localparam int RW   = 5;

    localparam int S_OP1 = 0, S_OP2 = 1, S_STALL = 2, S_BUBBLE = 3, S_FLUSH = 4, S_RV = 5,
                   S_RPC = 6, S_HALT = 7, S_SCNT = 8, S_FCNT = 9,
                   S_B_OP1 = 10, S_B_STALL = 11, S_B_BUBBLE = 12;

    typedef struct {
        int          cyc;
        int          sig;
        logic [31:0] val;
    } exp_t;

    logic            clk = 1'b0;
    logic            reset;
    logic [RW-1:0]   id_rs1, id_rs2, ex_rd, mem_rd, wb_rd;
    logic            id_use1, id_use2, ex_valid, ex_we, ex_is_load;
    logic            mem_valid, mem_we, wb_valid, wb_we, branch_taken_i, halt_i;
    logic [XLEN-1:0] ex_result, mem_result, wb_data, rf_op1, rf_op2, branch_target_i;

    logic [XLEN-1:0] a_op1, a_op2, a_rpc, a_scnt, a_fcnt;
    logic            a_stall, a_bubble, a_flush, a_rv, a_halt;
    logic [XLEN-1:0] b_op1, b_op2, b_rpc, b_scnt, b_fcnt;
    logic            b_stall, b_bubble, b_flush, b_rv, b_halt;

    exp_t sb[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    rv32i_hazard_unit #(.XLEN(XLEN), .NREG(32), .LOAD_LAT(3), .FLUSH_DEPTH(2), .FWD_EN(1)) dut_a (
        .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use1(id_use1), .id_use2(id_use2),
        .ex_valid(ex_valid), .ex_we(ex_we), .ex_is_load(ex_is_load), .ex_rd(ex_rd), .ex_result(ex_result),
        .mem_valid(mem_valid), .mem_we(mem_we), .mem_rd(mem_rd), .mem_result(mem_result),
        .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .rf_op1(rf_op1), .rf_op2(rf_op2), .branch_taken_i(branch_taken_i),
        .branch_target_i(branch_target_i), .halt_i(halt_i),
        .op1_o(a_op1), .op2_o(a_op2), .stall_o(a_stall), .bubble_o(a_bubble), .flush_o(a_flush),
        .redirect_valid_o(a_rv), .redirect_pc_o(a_rpc), .halted_o(a_halt),
        .stall_cnt_o(a_scnt), .flush_cnt_o(a_fcnt)
    );

    rv32i_hazard_unit #(.XLEN(XLEN), .NREG(32), .LOAD_LAT(1), .FLUSH_DEPTH(2), .FWD_EN(0)) dut_b (
        .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use1(id_use1), .id_use2(id_use2),
        .ex_valid(ex_valid), .ex_we(ex_we), .ex_is_load(ex_is_load), .ex_rd(ex_rd), .ex_result(ex_result),
        .mem_valid(mem_valid), .mem_we(mem_we), .mem_rd(mem_rd), .mem_result(mem_result),
        .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .rf_op1(rf_op1), .rf_op2(rf_op2), .branch_taken_i(branch_taken_i),
        .branch_target_i(branch_target_i), .halt_i(halt_i),
        .op1_o(b_op1), .op2_o(b_op2), .stall_o(b_stall), .bubble_o(b_bubble), .flush_o(b_flush),
        .redirect_valid_o(b_rv), .redirect_pc_o(b_rpc), .halted_o(b_halt),
        .stall_cnt_o(b_scnt), .flush_cnt_o(b_fcnt)
    );

    function automatic logic [31:0] actual(input int sig);
        case (sig)
            S_OP1:      return a_op1;
            S_OP2:      return a_op2;
            S_STALL:    return {31'd0, a_stall};
            S_BUBBLE:   return {31'd0, a_bubble};
            S_FLUSH:    return {31'd0, a_flush};
            S_RV:       return {31'd0, a_rv};
            S_RPC:      return a_rpc;
            S_HALT:     return {31'd0, a_halt};
            S_SCNT:     return a_scnt;
            S_FCNT:     return a_fcnt;
            S_B_OP1:    return b_op1;
            S_B_STALL:  return {31'd0, b_stall};
            S_B_BUBBLE: return {31'd0, b_bubble};
            default:    return 32'hFFFF_FFFF;
        endcase
    endfunction

    function automatic string sig_name(input int sig);
        case (sig)
            S_OP1:      return "op1";
            S_OP2:      return "op2";
            S_STALL:    return "stall";
            S_BUBBLE:   return "bubble";
            S_FLUSH:    return "flush";
            S_RV:       return "redirect_valid";
            S_RPC:      return "redirect_pc";
            S_HALT:     return "halted";
            S_SCNT:     return "stall_cnt";
            S_FCNT:     return "flush_cnt";
            S_B_OP1:    return "nofwd_op1";
            S_B_STALL:  return "nofwd_stall";
            S_B_BUBBLE: return "nofwd_bubble";
            default:    return "unknown";
        endcase
    endfunction

    task automatic expect_val(input int sig, input logic [31:0] v);
        exp_t e;
        e.cyc = cyc;
        e.sig = sig;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        id_rs1 = '0; id_rs2 = '0; id_use1 = 1'b0; id_use2 = 1'b0;
        ex_valid = 1'b0; ex_we = 1'b0; ex_is_load = 1'b0; ex_rd = '0; ex_result = '0;
        mem_valid = 1'b0; mem_we = 1'b0; mem_rd = '0; mem_result = '0;
        wb_valid = 1'b0; wb_we = 1'b0; wb_rd = '0; wb_data = '0;
        rf_op1 = 32'h0000_DEAD; rf_op2 = 32'h0000_BEEF;
        branch_taken_i = 1'b0; branch_target_i = '0; halt_i = 1'b0;
    endtask

    // Cycle counter shared by stimulus and monitor to tag expectations.
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: at each falling edge, pop and compare every expectation tagged for this cycle.
    initial forever begin
        exp_t        e;
        logic [31:0] got;
        @(negedge clk);
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            checks++;
            got = actual(e.sig);
            if (e.cyc < cyc) begin
                errors++;
                $display("FAIL %s cycle %0d: expectation not sampled (expected 0x%0h)",
                         sig_name(e.sig), e.cyc, e.val);
            end else if (got !== e.val) begin
                errors++;
                $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h",
                         sig_name(e.sig), e.cyc, got, e.val);
            end
        end
    end

    initial begin
        reset = 1'b1;
        clr();
        tick();
        tick();
        expect_val(S_STALL, 32'd0); expect_val(S_FLUSH, 32'd0); expect_val(S_RV, 32'd0);
        expect_val(S_RPC, 32'd0);   expect_val(S_HALT, 32'd0);  expect_val(S_SCNT, 32'd0);
        expect_val(S_FCNT, 32'd0);
        reset = 1'b0;
        tick();

        // EX forwarding of an ALU result.
        ex_valid = 1'b1; ex_we = 1'b1; ex_rd = 5'd5; ex_result = 32'h10;
        id_rs1 = 5'd5; id_use1 = 1'b1;
        expect_val(S_OP1, 32'h10); expect_val(S_OP2, 32'd0); expect_val(S_STALL, 32'd0);
        expect_val(S_BUBBLE, 32'd0);
        tick();

        // Priority EX > MEM > WB > RF.
        ex_result = 32'hA;
        mem_valid = 1'b1; mem_we = 1'b1; mem_rd = 5'd5; mem_result = 32'hB;
        wb_valid = 1'b1; wb_we = 1'b1; wb_rd = 5'd5; wb_data = 32'hC;
        id_rs2 = 5'd5; id_use2 = 1'b1;
        expect_val(S_OP1, 32'hA); expect_val(S_OP2, 32'hA);
        tick();
        ex_valid = 1'b0;
        expect_val(S_OP1, 32'hB);
        tick();
        mem_valid = 1'b0;
        expect_val(S_OP1, 32'hC);
        tick();
        wb_valid = 1'b0;
        expect_val(S_OP1, 32'h0000_DEAD); expect_val(S_OP2, 32'h0000_BEEF);
        tick();
        // x0 source with an x0 writer in EX reads as zero.
        ex_valid = 1'b1; ex_we = 1'b1; ex_rd = 5'd0; ex_result = 32'h55;
        id_rs1 = 5'd0; id_rs2 = 5'd0;
        expect_val(S_OP1, 32'd0); expect_val(S_STALL, 32'd0);
        tick();

        // Load-use with LOAD_LAT=3: three stall cycles.
        clr();
        ex_valid = 1'b1; ex_we = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd7;
        id_rs1 = 5'd7; id_use1 = 1'b1;
        expect_val(S_STALL, 32'd1); expect_val(S_BUBBLE, 32'd1); expect_val(S_SCNT, 32'd0);
        tick();
        ex_valid = 1'b0; ex_is_load = 1'b0;
        expect_val(S_STALL, 32'd1); expect_val(S_BUBBLE, 32'd1); expect_val(S_SCNT, 32'd1);
        tick();
        expect_val(S_STALL, 32'd1); expect_val(S_SCNT, 32'd2);
        tick();
        expect_val(S_STALL, 32'd0); expect_val(S_BUBBLE, 32'd0); expect_val(S_SCNT, 32'd3);
        tick();

        // Taken branch while a load stall is pending.
        ex_valid = 1'b1; ex_we = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd7;
        expect_val(S_STALL, 32'd1);
        tick();
        ex_we = 1'b0; ex_is_load = 1'b0; ex_rd = 5'd0;
        branch_taken_i = 1'b1; branch_target_i = 32'h200;
        expect_val(S_STALL, 32'd0); expect_val(S_RV, 32'd0); expect_val(S_SCNT, 32'd4);
        tick();
        // Wrong-path branch and load-use while flushing must be ignored.
        ex_we = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd7; branch_target_i = 32'h300;
        expect_val(S_RV, 32'd1); expect_val(S_RPC, 32'h200); expect_val(S_FLUSH, 32'd1);
        expect_val(S_STALL, 32'd0); expect_val(S_BUBBLE, 32'd0); expect_val(S_FCNT, 32'd0);
        tick();
        clr();
        expect_val(S_FLUSH, 32'd1); expect_val(S_RV, 32'd0); expect_val(S_RPC, 32'h200);
        expect_val(S_FCNT, 32'd1);
        tick();
        expect_val(S_FLUSH, 32'd0); expect_val(S_RV, 32'd0); expect_val(S_SCNT, 32'd4);

        // Halt beats a same-cycle branch.
        halt_i = 1'b1; ex_valid = 1'b1; branch_taken_i = 1'b1; branch_target_i = 32'h400;
        tick();
        clr();
        expect_val(S_HALT, 32'd1); expect_val(S_STALL, 32'd1); expect_val(S_BUBBLE, 32'd1);
        expect_val(S_FLUSH, 32'd0); expect_val(S_RV, 32'd0); expect_val(S_RPC, 32'h200);
        expect_val(S_SCNT, 32'd4);
        tick();
        expect_val(S_HALT, 32'd1); expect_val(S_SCNT, 32'd5);
        reset = 1'b1;
        tick();
        expect_val(S_HALT, 32'd0); expect_val(S_STALL, 32'd0); expect_val(S_FLUSH, 32'd0);
        expect_val(S_RV, 32'd0);   expect_val(S_RPC, 32'd0);   expect_val(S_SCNT, 32'd0);
        expect_val(S_FCNT, 32'd0);
        tick();
        reset = 1'b0;
        tick();

        // Forwarding disabled: stall until the WB producer retires.
        mem_valid = 1'b1; mem_we = 1'b1; mem_rd = 5'd3; mem_result = 32'h33;
        id_rs1 = 5'd3; id_use1 = 1'b1; rf_op1 = 32'h1111;
        expect_val(S_B_OP1, 32'h1111); expect_val(S_B_STALL, 32'd1); expect_val(S_B_BUBBLE, 32'd1);
        expect_val(S_OP1, 32'h33); expect_val(S_STALL, 32'd0);
        tick();
        mem_valid = 1'b0; wb_valid = 1'b1; wb_we = 1'b1; wb_rd = 5'd3; wb_data = 32'h33;
        expect_val(S_B_OP1, 32'h1111); expect_val(S_B_STALL, 32'd1); expect_val(S_OP1, 32'h33);
        tick();
        wb_valid = 1'b0; rf_op1 = 32'h33;
        expect_val(S_B_OP1, 32'h33); expect_val(S_B_STALL, 32'd0);
        tick();
        mem_valid = 1'b1; id_use1 = 1'b0;
        expect_val(S_B_STALL, 32'd0);
        tick();

        for (int i = 0; i < 10 && sb.size() > 0; i++) begin
            tick();
        end
        if (sb.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
